// File: rtl/conv_pass_scheduler_if.sv
// Handshake bundle between the layer sequencer and its four agents
// (weight loader, ifmap loader, PE array, output writer).
interface conv_pass_scheduler_if #(
    parameter int GRP_WIDTH  = 5,
    parameter int TILE_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  wgt_load;
    logic                  wgt_done;
    logic                  ifm_load;
    logic                  ifm_done;
    logic                  compute_start;
    logic                  compute_done;
    logic                  store_start;
    logic                  store_done;
    logic [GRP_WIDTH-1:0]  group_idx;
    logic [TILE_WIDTH-1:0] tile_idx;
    logic [4:0]            size;

    // Handshake: each request (wgt_load, ifm_load, compute_start, store_start) is a
    // one-cycle pulse; the matching *_done is accepted on any edge while the
    // sequencer waits for it and ignored at every other time, so an agent may
    // hold its done high or pulse it; group_idx/tile_idx/size are stable from
    // the request until the matching done has been accepted.
    modport master (
        input  start, wgt_done, ifm_done, compute_done, store_done,
        output busy, done, wgt_load, ifm_load, compute_start, store_start,
        output group_idx, tile_idx, size
    );

    modport slave (
        output start, wgt_done, ifm_done, compute_done, store_done,
        input  busy, done, wgt_load, ifm_load, compute_start, store_start,
        input  group_idx, tile_idx, size
    );
endinterface

// File: rtl/conv_pass_scheduler.sv
// Layer sequencer: per filter group one weight load, then per output tile an
// ifmap load, a compute pass and a store pass, each closed by its done handshake.
module conv_pass_scheduler #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NO_CHANNEL    = 3,
    parameter int NO_FILTER     = 16,
    parameter int NO_TILE       = 4,
    parameter int GRP_WIDTH     = 5,
    parameter int TILE_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_pass_scheduler_if.master bus,
    output logic [3:0]           dbg_state,
    output logic [15:0]          wgt_words
);
    localparam int NO_GROUP  = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int LAST_SIZE = (NO_FILTER % SYSTOLIC_SIZE == 0) ? SYSTOLIC_SIZE
                                                                : NO_FILTER % SYSTOLIC_SIZE;
    localparam int WGT_WORDS = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;

    localparam logic [4:0]            FULL_SZ   = 5'(SYSTOLIC_SIZE);
    localparam logic [4:0]            LAST_SZ   = 5'(LAST_SIZE);
    localparam logic [4:0]            FIRST_SZ  = (NO_GROUP == 1) ? LAST_SZ : FULL_SZ;
    localparam logic [GRP_WIDTH-1:0]  LAST_GRP  = GRP_WIDTH'(NO_GROUP - 1);
    localparam logic [TILE_WIDTH-1:0] LAST_TILE = TILE_WIDTH'(NO_TILE - 1);

    typedef enum logic [3:0] {
        IDLE,
        WGT_REQ,
        WGT_WAIT,
        IFM_REQ,
        IFM_WAIT,
        CMP_REQ,
        CMP_WAIT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wgt_q, ifm_q, cmp_q, st_q;
    logic [GRP_WIDTH-1:0]  group_q, group_d, group_nxt;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic [4:0]            size_q, size_d;

    assign group_nxt = group_q + GRP_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        group_d = group_q;
        tile_d  = tile_q;
        size_d  = size_q;
        case (state_q)
            // done_q marks the completion cycle; a start there is still ignored
            IDLE: begin
                if (bus.start && !done_q) begin
                    state_d = WGT_REQ;
                    busy_d  = 1'b1;
                    group_d = '0;
                    tile_d  = '0;
                    size_d  = FIRST_SZ;
                end
            end
            WGT_REQ:  state_d = WGT_WAIT;
            WGT_WAIT: if (bus.wgt_done) state_d = IFM_REQ;
            IFM_REQ:  state_d = IFM_WAIT;
            IFM_WAIT: if (bus.ifm_done) state_d = CMP_REQ;
            CMP_REQ:  state_d = CMP_WAIT;
            CMP_WAIT: if (bus.compute_done) state_d = ST_REQ;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.store_done) begin
                    if (tile_q < LAST_TILE) begin
                        // weights of the current group stay loaded for the next tile
                        tile_d  = tile_q + TILE_WIDTH'(1);
                        state_d = IFM_REQ;
                    end else if (group_q < LAST_GRP) begin
                        group_d = group_nxt;
                        tile_d  = '0;
                        size_d  = (group_nxt == LAST_GRP) ? LAST_SZ : FULL_SZ;
                        state_d = WGT_REQ;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wgt_q   <= 1'b0;
            ifm_q   <= 1'b0;
            cmp_q   <= 1'b0;
            st_q    <= 1'b0;
            group_q <= '0;
            tile_q  <= '0;
            size_q  <= FULL_SZ;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            // request flops mirror occupancy of the matching REQ state
            wgt_q   <= (state_d == WGT_REQ);
            ifm_q   <= (state_d == IFM_REQ);
            cmp_q   <= (state_d == CMP_REQ);
            st_q    <= (state_d == ST_REQ);
            group_q <= group_d;
            tile_q  <= tile_d;
            size_q  <= size_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.wgt_load      = wgt_q;
    assign bus.ifm_load      = ifm_q;
    assign bus.compute_start = cmp_q;
    assign bus.store_start   = st_q;
    assign bus.group_idx     = group_q;
    assign bus.tile_idx      = tile_q;
    assign bus.size          = size_q;
    assign dbg_state         = state_q;
    assign wgt_words         = 16'(WGT_WORDS);
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Bench for conv_pass_scheduler: three layer shapes, a scoreboard of expected
// request/done events per instance, and randomised agent latencies.
module tb_conv_pass_scheduler;
    localparam int W = 22;  // {kind[2:0], busy, group[4:0], tile[7:0], size[4:0]}

    logic        clk;
    logic        rst_v   [3];
    logic        start_v [3];
    logic        hold    [3];
    logic        spur_en;
    logic        req     [3][4];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [4:0]  grp_v   [3];
    logic [7:0]  tile_v  [3];
    logic [4:0]  size_v  [3];
    logic [3:0]  dbg_v   [3];
    logic [15:0] words_v [3];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- layer shapes and reference model ----------------
    function automatic int nf_of(int k);
        return (k == 0) ? 16 : (k == 1) ? 40 : 32;
    endfunction
    function automatic int nt_of(int k);
        return (k == 1) ? 2 : 4;
    endfunction
    function automatic int ng_of(int k);
        return (nf_of(k) + 15) / 16;
    endfunction
    function automatic int lat_of(int k);
        return 2 * ng_of(k) + 6 * ng_of(k) * nt_of(k);
    endfunction

    function automatic logic [W-1:0] mk(int kind, logic b, int g, int t, int sz);
        return {kind[2:0], b, g[4:0], t[7:0], sz[4:0]};
    endfunction

    function automatic void push_ev(int k, logic [W-1:0] e);
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction
    function automatic int q_size(int k);
        return (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
    endfunction
    function automatic logic [W-1:0] pop_ev(int k);
        case (k)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction
    function automatic void clear_q(int k);
        case (k)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endfunction

    // One layer: per group a weight load, per tile ifm/compute/store, then done.
    function automatic void push_layer(int k);
        int nf, nt, ng, sz;
        nf = nf_of(k);
        nt = nt_of(k);
        ng = ng_of(k);
        sz = 16;
        for (int g = 0; g < ng; g++) begin
            sz = (g == ng - 1 && nf % 16 != 0) ? nf % 16 : 16;
            push_ev(k, mk(0, 1'b1, g, 0, sz));
            for (int t = 0; t < nt; t++) begin
                push_ev(k, mk(1, 1'b1, g, t, sz));
                push_ev(k, mk(2, 1'b1, g, t, sz));
                push_ev(k, mk(3, 1'b1, g, t, sz));
            end
        end
        push_ev(k, mk(4, 1'b0, ng - 1, nt - 1, sz));
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic void compare_ev(int k, logic [W-1:0] act);
        if (q_size(k) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL event_dut%0d: got %0h, required nothing (no event expected)", k, act);
        end else begin
            chk($sformatf("event_dut%0d", k), 32'(act), 32'(pop_ev(k)));
        end
    endfunction

    // ---------------- DUTs, agents, monitors ----------------
    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int NFI = (i == 0) ? 16 : (i == 1) ? 40 : 32;
        localparam int NTI = (i == 1) ? 2 : 4;

        conv_pass_scheduler_if #(.GRP_WIDTH(5), .TILE_WIDTH(8)) bus ();

        conv_pass_scheduler #(
            .SYSTOLIC_SIZE(16), .KERNEL_SIZE(3), .NO_CHANNEL(3),
            .NO_FILTER(NFI), .NO_TILE(NTI), .GRP_WIDTH(5), .TILE_WIDTH(8)
        ) dut (
            .clk       (clk),
            .rst       (rst_v[i]),
            .bus       (bus),
            .dbg_state (dbg_v[i]),
            .wgt_words (words_v[i])
        );

        for (genvar c = 0; c < 4; c++) begin : g_ag
            logic d;
            logic s;
            initial begin
                int dly;
                d = 1'b0;
                s = 1'b0;
                forever begin
                    @(negedge clk);
                    if (req[i][c] && !hold[i]) begin
                        dly = $urandom_range(0, 5);
                        @(negedge clk);
                        if (c == 1 && spur_en && dly >= 1 && $urandom_range(0, 1) == 1) begin
                            s = 1'b1;
                            @(negedge clk);
                            s = 1'b0;
                            dly = dly - 1;
                        end
                        repeat (dly) @(negedge clk);
                        d = 1'b1;
                        @(negedge clk);
                        d = 1'b0;
                    end
                end
            end
        end

        assign bus.start        = start_v[i];
        assign bus.wgt_done     = hold[i] | g_ag[0].d;
        assign bus.ifm_done     = hold[i] | g_ag[1].d;
        assign bus.compute_done = hold[i] | g_ag[2].d | g_ag[1].s;
        assign bus.store_done   = hold[i] | g_ag[3].d;

        assign req[i][0] = bus.wgt_load;
        assign req[i][1] = bus.ifm_load;
        assign req[i][2] = bus.compute_start;
        assign req[i][3] = bus.store_start;
        assign busy_v[i] = bus.busy;
        assign done_v[i] = bus.done;
        assign grp_v[i]  = bus.group_idx;
        assign tile_v[i] = bus.tile_idx;
        assign size_v[i] = bus.size;

        logic [3:0] prev;
        initial begin
            prev = '0;
            forever begin
                @(negedge clk);
                if (rst_v[i]) begin
                    prev = '0;
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        if (req[i][c]) begin
                            chk($sformatf("pulse_width_dut%0d_req%0d", i, c), 32'(prev[c]), 32'd0);
                            compare_ev(i, mk(c, busy_v[i], grp_v[i], tile_v[i], size_v[i]));
                        end
                    end
                    if (done_v[i])
                        compare_ev(i, mk(4, busy_v[i], grp_v[i], tile_v[i], size_v[i]));
                    for (int c = 0; c < 4; c++) prev[c] = req[i][c];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1'b1;
        end
        chk($sformatf("done_seen_dut%0d", k), 32'(seen), 32'd1);
    endtask

    task automatic check_reset(int k);
        chk($sformatf("rst_busy_dut%0d", k), 32'(busy_v[k]), 32'd0);
        chk($sformatf("rst_done_dut%0d", k), 32'(done_v[k]), 32'd0);
        for (int c = 0; c < 4; c++)
            chk($sformatf("rst_req%0d_dut%0d", c, k), 32'(req[k][c]), 32'd0);
        chk($sformatf("rst_group_dut%0d", k), 32'(grp_v[k]), 32'd0);
        chk($sformatf("rst_tile_dut%0d", k), 32'(tile_v[k]), 32'd0);
        chk($sformatf("rst_size_dut%0d", k), 32'(size_v[k]), 32'd16);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat [3];
        int bc  [3];
        logic found;
        spur_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rst_v[k]   = 1'b1;
            start_v[k] = 1'b0;
            hold[k]    = 1'b1;
            lat[k]     = -1;
            bc[k]      = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_reset(k);
            chk($sformatf("wgt_words_dut%0d", k), 32'(words_v[k]), 32'd27);
            rst_v[k] = 1'b0;
        end
        @(negedge clk);

        // All three shapes with done inputs held high: minimum latency.
        for (int k = 0; k < 3; k++) begin
            push_layer(k);
            start_v[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (lat[k] < 0) begin
                    if (done_v[k]) lat[k] = n - 1;
                    else if (busy_v[k]) bc[k]++;
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("latency_dut%0d", k), 32'(lat[k]), 32'(lat_of(k)));
            chk($sformatf("busy_cycles_dut%0d", k), 32'(bc[k]), 32'(lat_of(k)));
        end
        repeat (2) @(negedge clk);

        // Randomised agent delays with spurious compute_done during IFM_WAIT.
        hold[0] = 1'b0;
        spur_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            push_layer(0);
            pulse_start(0);
            wait_done(0, 1000);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        spur_en = 1'b0;
        hold[0] = 1'b1;
        repeat (8) @(negedge clk);

        // start reasserted in WGT_WAIT and in the done cycle.
        push_layer(0);
        pulse_start(0);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("busy_after_start_in_wgt_wait", 32'(busy_v[0]), 32'd1);
        chk("group_after_start_in_wgt_wait", 32'(grp_v[0]), 32'd0);
        chk("tile_after_start_in_wgt_wait", 32'(tile_v[0]), 32'd0);
        wait_done(0, 200);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("busy_after_start_in_done_cycle", 32'(busy_v[0]), 32'd0);
        repeat (4) @(negedge clk);
        chk("still_idle_after_done_cycle_start", 32'(busy_v[0]), 32'd0);

        // start in the cycle right after done begins a new layer.
        push_layer(0);
        pulse_start(0);
        wait_done(0, 200);
        @(negedge clk);
        push_layer(0);
        pulse_start(0);
        chk("busy_after_start_after_done", 32'(busy_v[0]), 32'd1);
        wait_done(0, 200);
        repeat (3) @(negedge clk);

        // Reset during CMP_WAIT of tile 2, then a full fresh layer.
        push_layer(0);
        pulse_start(0);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (req[0][2] && tile_v[0] == 8'd2) found = 1'b1;
        end
        chk("compute_tile2_seen", 32'(found), 32'd1);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check_reset(0);
        rst_v[0] = 1'b0;
        clear_q(0);
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 32'(done_v[0]), 32'd0);
        push_layer(0);
        pulse_start(0);
        wait_done(0, 200);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++)
            chk($sformatf("queue_drained_dut%0d", k), 32'(q_size(k)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
